// File: rtl/qmfir_uart_pkg.sv
// ==== qmfir_uart_pkg : shared encodings for the QMFIR UART burst interface ====
// ==== rev 1.0 ====
`default_nettype none

package qmfir_uart_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR    = 4'd1,
    LEN     = 4'd2,
    WDATA   = 4'd3,
    WCOMMIT = 4'd4,
    WACK    = 4'd5,
    RREQ    = 4'd6,
    RWAIT   = 4'd7,
    RSEND   = 4'd8
  } state_t;

  localparam int CMD_WR  = 7;
  localparam int CMD_SEL = 6;

  localparam logic [7:0] WR_ACK_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/qmfir_byte_shreg.sv
// ==== qmfir_byte_shreg : N-byte shift-in/shift-out register with byte counter ====
// ==== rev 1.0 ====
`default_nettype none

module qmfir_byte_shreg #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_in,
  input  logic                  shift_out,
  input  logic                  load,
  input  logic [7:0]            in_byte,
  input  logic [8*NBYTES-1:0]   load_data,
  output logic [8*NBYTES-1:0]   data,
  output logic [7:0]            msb_byte,
  output logic                  last
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CW-1:0] count;
  logic [W-1:0]  shifted_in;

  // New bytes enter at the LSB so the first byte received ends up as the MSB.
  always_comb begin
    shifted_in      = data << 8;
    shifted_in[7:0] = in_byte;
  end

  assign msb_byte = data[W-1 -: 8];
  assign last     = (count == CW'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else begin
      if (load)
        data <= load_data;
      else if (shift_in)
        data <= shifted_in;
      else if (shift_out)
        data <= data << 8;

      if (clr)
        count <= '0;
      else if (shift_in || shift_out)
        count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/qmfir_uart_burst_if.sv
// ==== qmfir_uart_burst_if : UART byte-frame to QMFIR bus bridge with bursts ====
// ==== rev 1.0 ====
`default_nettype none

module qmfir_uart_burst_if
  import qmfir_uart_pkg::*;
#(
  parameter int         DATA_BYTES = 4,
  parameter int         ADDR_BYTES = 2,
  parameter int         RD_TIMEOUT = 255,
  parameter logic [7:0] WR_ACK     = WR_ACK_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_empty,
  output logic                    rx_re,
  output logic [7:0]              tx_data,
  output logic                    tx_we,
  input  logic                    tx_full,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic                    bus_sel,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  output logic                    bus_we,
  output logic                    bus_re,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  input  logic                    bus_rvalid,
  output logic                    busy,
  output logic                    rd_err
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  state_t        state, state_next;
  logic          is_write;
  logic [7:0]    words_left;
  logic [TW-1:0] tcnt;

  logic          words_done, rd_timeout;
  logic          addr_shift, wd_shift, rd_shift, rd_load, addr_inc, shreg_clr;
  logic          addr_last, wd_last, rd_last;
  logic [7:0]    rd_byte;
  logic [DW-1:0] rd_load_data;
  logic [DW-1:0] rd_word_unused;
  logic [7:0]    addr_msb_unused, wdata_msb_unused;

  assign words_done   = (words_left == 8'd0);
  assign rd_timeout   = (tcnt == TW'(RD_TIMEOUT - 1));
  assign rd_load_data = bus_rvalid ? bus_rdata : '1;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_empty) state_next = ADDR;
      ADDR:    if (!rx_empty && addr_last) state_next = LEN;
      LEN:     if (!rx_empty) state_next = is_write ? WDATA : RREQ;
      WDATA:   if (!rx_empty && wd_last) state_next = WCOMMIT;
      WCOMMIT: state_next = words_done ? WACK : WDATA;
      WACK:    if (!tx_full) state_next = IDLE;
      RREQ:    state_next = RWAIT;
      RWAIT:   if (bus_rvalid || rd_timeout) state_next = RSEND;
      RSEND:   if (!tx_full && rd_last) state_next = words_done ? IDLE : RREQ;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are suppressed while rst is high so a mid-burst reset issues nothing.
  always_comb begin
    rx_re   = 1'b0;
    tx_we   = 1'b0;
    tx_data = 8'h00;
    bus_we  = 1'b0;
    bus_re  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, ADDR, LEN, WDATA: rx_re = ~rx_empty;
        WCOMMIT: bus_we = 1'b1;
        WACK: begin
          tx_we   = ~tx_full;
          tx_data = WR_ACK;
        end
        RREQ:  bus_re = 1'b1;
        RSEND: begin
          tx_we   = ~tx_full;
          tx_data = rd_byte;
        end
        default: ;
      endcase
    end
    busy       = (state != IDLE);
    shreg_clr  = (state == IDLE);
    addr_shift = rx_re && (state == ADDR);
    wd_shift   = rx_re && (state == WDATA);
    rd_shift   = tx_we && (state == RSEND);
    rd_load    = (state == RWAIT) && (bus_rvalid || rd_timeout);
    addr_inc   = ((state == WCOMMIT) && !words_done) ||
                 (rd_shift && rd_last && !words_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_write   <= 1'b0;
      bus_sel    <= 1'b0;
      words_left <= 8'd0;
      tcnt       <= '0;
      rd_err     <= 1'b0;
    end else begin
      if (rx_re && (state == IDLE)) begin
        is_write <= rx_data[CMD_WR];
        bus_sel  <= rx_data[CMD_SEL];
      end
      if (rx_re && (state == LEN))
        words_left <= rx_data;
      else if (addr_inc)
        words_left <= words_left - 1'b1;
      if (state == RREQ)
        tcnt <= '0;
      else if (state == RWAIT)
        tcnt <= tcnt + 1'b1;
      if ((state == RWAIT) && !bus_rvalid && rd_timeout)
        rd_err <= 1'b1;
    end
  end

  qmfir_byte_shreg #(.NBYTES(ADDR_BYTES)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clr       (shreg_clr),
    .shift_in  (addr_shift),
    .shift_out (1'b0),
    .load      (addr_inc),
    .in_byte   (rx_data),
    .load_data (bus_addr + 1'b1),
    .data      (bus_addr),
    .msb_byte  (addr_msb_unused),
    .last      (addr_last)
  );

  qmfir_byte_shreg #(.NBYTES(DATA_BYTES)) u_wdata (
    .clk       (clk),
    .rst       (rst),
    .clr       (shreg_clr),
    .shift_in  (wd_shift),
    .shift_out (1'b0),
    .load      (1'b0),
    .in_byte   (rx_data),
    .load_data ('0),
    .data      (bus_wdata),
    .msb_byte  (wdata_msb_unused),
    .last      (wd_last)
  );

  qmfir_byte_shreg #(.NBYTES(DATA_BYTES)) u_rdata (
    .clk       (clk),
    .rst       (rst),
    .clr       (shreg_clr),
    .shift_in  (1'b0),
    .shift_out (rd_shift),
    .load      (rd_load),
    .in_byte   (8'h00),
    .load_data (rd_load_data),
    .data      (rd_word_unused),
    .msb_byte  (rd_byte),
    .last      (rd_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_qmfir_uart_burst_if.sv
// ==== tb_qmfir_uart_burst_if : directed self-checking bench for the UART burst bridge ====
// ==== rev 1.0 ====
`default_nettype none

module tb_qmfir_uart_burst_if;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [7:0]  rx_data = 8'h00;
  logic        rx_empty = 1'b1;
  logic        rx_re, tx_we, bus_sel, bus_we, bus_re, busy, rd_err;
  logic [7:0]  tx_data;
  logic        tx_full = 1'b0;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_rvalid = 1'b0;

  // Narrow instance: 2 data bytes, 1 address byte, short timeout
  logic [7:0]  rx_data2 = 8'h00;
  logic        rx_empty2 = 1'b1;
  logic        rx_re2, tx_we2, bus_sel2, bus_we2, bus_re2, busy2, rd_err2;
  logic [7:0]  tx_data2;
  logic [7:0]  bus_addr2;
  logic [15:0] bus_wdata2;

  qmfir_uart_burst_if u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty), .rx_re(rx_re),
    .tx_data(tx_data), .tx_we(tx_we), .tx_full(tx_full), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .busy(busy), .rd_err(rd_err)
  );

  qmfir_uart_burst_if #(.DATA_BYTES(2), .ADDR_BYTES(1), .RD_TIMEOUT(4)) u_dut2 (
    .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_empty(rx_empty2), .rx_re(rx_re2),
    .tx_data(tx_data2), .tx_we(tx_we2), .tx_full(1'b0), .bus_addr(bus_addr2),
    .bus_sel(bus_sel2), .bus_wdata(bus_wdata2), .bus_we(bus_we2), .bus_re(bus_re2),
    .bus_rdata(16'h0000), .bus_rvalid(1'b0), .busy(busy2), .rd_err(rd_err2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  rxq[$];
  logic [7:0]  rxq2[$];
  logic [31:0] rdq[$];
  logic [16:0] we_addr[$];
  logic [31:0] we_data[$];
  int          we_lat[$];
  logic [15:0] re_addr[$];
  logic [7:0]  txb[$];
  int          tx_cyc[$];
  logic [23:0] we2[$];
  logic [7:0]  txb2[$];
  int          re_cyc = 0;
  int          last_pop = 0;
  bit          pop1, pop2;
  bit          tog = 1'b0;

  // RX FIFO models: show-ahead head byte, popped on the edge after rx_re is seen
  initial forever begin
    @(negedge clk);
    pop1 = rx_re;
    pop2 = rx_re2;
    @(posedge clk);
    #1;
    if (pop1 && rxq.size() > 0) void'(rxq.pop_front());
    if (pop2 && rxq2.size() > 0) void'(rxq2.pop_front());
    rx_empty  = (rxq.size() == 0);
    rx_data   = rx_empty ? 8'h00 : rxq[0];
    rx_empty2 = (rxq2.size() == 0);
    rx_data2  = rx_empty2 ? 8'h00 : rxq2[0];
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_full = tog ? ~tx_full : 1'b0;
  end

  // Bus responder: answer each read request 3 cycles later from rdq
  initial forever begin
    @(negedge clk);
    if (bus_re && rdq.size() > 0) begin
      logic [31:0] d;
      d = rdq.pop_front();
      repeat (3) @(posedge clk);
      #1;
      bus_rvalid = 1'b1;
      bus_rdata  = d;
      @(posedge clk);
      #1;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus_we) begin
      we_addr.push_back({bus_sel, bus_addr});
      we_data.push_back(bus_wdata);
      we_lat.push_back(cyc - last_pop);
    end
    if (bus_re) begin
      re_addr.push_back(bus_addr);
      re_cyc = cyc;
    end
    if (tx_we) begin
      txb.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    if (rx_re) last_pop = cyc;
    if (bus_we2) we2.push_back({bus_addr2, bus_wdata2});
    if (tx_we2) txb2.push_back(tx_data2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] MISSING = 64'hFFFF_0000_0000_0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) rxq.push_back(v[8*i +: 8]);
  endtask

  task automatic send2(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) rxq2.push_back(v[8*i +: 8]);
  endtask

  task automatic clr();
    we_addr.delete(); we_data.delete(); we_lat.delete(); re_addr.delete();
    txb.delete(); tx_cyc.delete(); we2.delete(); txb2.delete();
  endtask

  task automatic wait_idle(input bit which, input int budget, input string tag);
    bit done = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (which == 1'b0) ? (!busy && rxq.size() == 0) : (!busy2 && rxq2.size() == 0);
    end
    chk({tag, " reaches idle"}, {63'd0, done}, 64'd1);
  endtask

  function automatic logic [63:0] tx_at(int i);
    return (i < txb.size()) ? {56'd0, txb[i]} : MISSING;
  endfunction
  function automatic logic [63:0] wa_at(int i);
    return (i < we_addr.size()) ? {47'd0, we_addr[i]} : MISSING;
  endfunction
  function automatic logic [63:0] wd_at(int i);
    return (i < we_data.size()) ? {32'd0, we_data[i]} : MISSING;
  endfunction
  function automatic logic [63:0] ra_at(int i);
    return (i < re_addr.size()) ? {48'd0, re_addr[i]} : MISSING;
  endfunction

  initial begin
    logic [63:0] exp_rd;
    bit          drained;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset bus_addr", {48'd0, bus_addr}, 64'd0);
    chk("reset bus_wdata", {32'd0, bus_wdata}, 64'd0);
    chk("reset bus_sel/rd_err", {62'd0, bus_sel, rd_err}, 64'd0);
    chk("reset tx_data", {56'd0, tx_data}, 64'd0);
    chk("reset strobes", {60'd0, rx_re, tx_we, bus_we, bus_re}, 64'd0);

    // Single write to the register file
    clr();
    send(128'h80001000_DEADBEEF, 8);
    wait_idle(1'b0, 100, "single write");
    chk("wr1 count", 64'(we_addr.size()), 64'd1);
    chk("wr1 sel+addr", wa_at(0), 64'h0_0010);
    chk("wr1 data", wd_at(0), 64'hDEADBEEF);
    chk("wr1 latency", (we_lat.size() > 0) ? 64'(we_lat[0]) : MISSING, 64'd1);
    chk("wr1 tx count", 64'(txb.size()), 64'd1);
    chk("wr1 ack", tx_at(0), 64'hA5);

    // Three-word burst write to memory
    clr();
    send(128'hC0010002_A0A1A2A3_B0B1B2B3_C0C1C2C3, 16);
    wait_idle(1'b0, 200, "burst write");
    chk("burst count", 64'(we_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("burst addr%0d", i), wa_at(i), 64'h1_0100 + 64'(i));
      chk($sformatf("burst data%0d", i), wd_at(i), 64'hA0A1A2A3 + 64'(i) * 64'h10101010);
    end
    chk("burst tx count", 64'(txb.size()), 64'd1);
    chk("burst ack", tx_at(0), 64'hA5);

    // Burst read across the address wrap with TX back-pressure
    clr();
    rdq.push_back(32'h11223344);
    rdq.push_back(32'h55667788);
    tog = 1'b1;
    send(128'h40FFFF01, 4);
    wait_idle(1'b0, 300, "burst read");
    tog = 1'b0;
    chk("read re count", 64'(re_addr.size()), 64'd2);
    chk("read re addr0", ra_at(0), 64'hFFFF);
    chk("read re addr1 wrap", ra_at(1), 64'h0000);
    chk("read tx count", 64'(txb.size()), 64'd8);
    exp_rd = 64'h1122334455667788;
    for (int i = 0; i < 8; i++)
      chk($sformatf("read tx byte%0d", i), tx_at(i), {56'd0, exp_rd[63 - 8*i -: 8]});
    chk("read rd_err clear", {63'd0, rd_err}, 64'd0);

    // Read with no response: timeout substitutes all-ones
    repeat (2) @(negedge clk);
    clr();
    send(128'h00000500, 4);
    wait_idle(1'b0, 400, "read timeout");
    chk("timeout tx count", 64'(txb.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("timeout tx byte%0d", i), tx_at(i), 64'hFF);
    chk("timeout rd_err", {63'd0, rd_err}, 64'd1);
    chk("timeout latency", (tx_cyc.size() > 0) ? 64'(tx_cyc[0] - re_cyc) : MISSING, 64'd256);

    // rd_err stays set across a later frame
    clr();
    send(128'h80003000_CAFEF00D, 8);
    wait_idle(1'b0, 100, "write after timeout");
    chk("post-timeout data", wd_at(0), 64'hCAFEF00D);
    chk("rd_err sticky", {63'd0, rd_err}, 64'd1);

    // Reset after the 2nd data byte of a write
    clr();
    send(128'h80001000_DEAD, 6);
    drained = 1'b0;
    for (int i = 0; i < 50 && !drained; i++) begin
      @(negedge clk);
      drained = (rxq.size() == 0);
    end
    chk("midburst drained", {63'd0, drained}, 64'd1);
    chk("midburst busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("in-reset strobes", {60'd0, rx_re, tx_we, bus_we, bus_re}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset busy", {63'd0, busy}, 64'd0);
    chk("post-reset wdata", {32'd0, bus_wdata}, 64'd0);
    chk("post-reset addr", {48'd0, bus_addr}, 64'd0);
    chk("post-reset rd_err", {63'd0, rd_err}, 64'd0);
    chk("post-reset no write", 64'(we_addr.size()), 64'd0);
    send(128'h80002000_01020304, 8);
    wait_idle(1'b0, 100, "write after reset");
    chk("redecode sel+addr", wa_at(0), 64'h0_0020);
    chk("redecode data", wd_at(0), 64'h01020304);

    // Narrow instance: one-byte address, two-byte word
    clr();
    send2(128'h80_07_00_ABCD, 5);
    wait_idle(1'b1, 100, "narrow write");
    chk("narrow addr+data", (we2.size() > 0) ? {40'd0, we2[0]} : MISSING, 64'h07ABCD);
    chk("narrow ack", (txb2.size() > 0) ? {56'd0, txb2[0]} : MISSING, 64'hA5);
    clr();
    send2(128'h00_09_00, 3);
    wait_idle(1'b1, 100, "narrow timeout");
    chk("narrow timeout count", 64'(txb2.size()), 64'd2);
    chk("narrow timeout bytes", (txb2.size() > 1) ? {48'd0, txb2[0], txb2[1]} : MISSING, 64'hFFFF);
    chk("narrow rd_err", {63'd0, rd_err2}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qmfir_uart_burst_if.md
Name: qmfir_uart_burst_if

Overview:
- Parametrised byte-protocol engine between the UART byte FIFOs (show-ahead RX, TX with full flag) and the QMFIR memory/register bus.
- Generalises the single-word host interface to configurable data and address widths.
- Adds burst transfers with address auto-increment, TX back-pressure, a read-wait handshake with timeout, and a write-acknowledge byte.

Parameters:
- DATA_BYTES, 4, bytes per bus word (bus width DW = 8*DATA_BYTES); range 1..8.
- ADDR_BYTES, 2, address bytes on the wire (AW = 8*ADDR_BYTES); range 1..4.
- RD_TIMEOUT, 255, cycles to wait for bus_rvalid before substituting error data; must be at least 1.
- WR_ACK, 8'hA5, byte returned after every completed write burst.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  RX FIFO head byte (show-ahead)
- rx_empty  in  1  RX FIFO empty
- rx_re  out  1  RX pop; rx_data is consumed in the same cycle
- tx_data  out  8  TX byte
- tx_we  out  1  TX push
- tx_full  in  1  TX FIFO full
- bus_addr  out  AW  word address
- bus_sel  out  1  1 = memory, 0 = register file
- bus_wdata  out  DW  write data
- bus_we  out  1  one-cycle write strobe
- bus_re  out  1  one-cycle read request
- bus_rdata  in  DW  read data, valid when bus_rvalid is high
- bus_rvalid  in  1  read data valid
- busy  out  1  high whenever state is not IDLE
- rd_err  out  1  sticky flag, set on read timeout, cleared only by rst

Behaviour:
- Reset:
  - rst is synchronous and active-high; it overrides every other input.
  - On reset the state goes to IDLE, all strobes are 0, and bus_addr, bus_wdata, bus_sel, tx_data and rd_err are 0.
  - Reset mid-burst discards the partial word and issues no bus strobe in that cycle.
- Frame format (all fields MSB-first):
  - CMD byte: [7] = write, [6] = bus_sel, [5:0] reserved and ignored.
  - ADDR_BYTES address bytes.
  - LEN byte: word count = LEN + 1 (1..256).
  - Write frames follow with (LEN+1)*DATA_BYTES data bytes.
- rx_re is asserted combinationally as ~rx_empty in CMD, ADDR, LEN and WDATA, and only there. The byte is captured on the cycle rx_re is high.
- States:
  - IDLE -> ADDR when a CMD byte is popped.
  - ADDR: shift in ADDR_BYTES bytes, then -> LEN.
  - LEN -> WDATA if write, else -> RREQ.
  - WDATA: shift DATA_BYTES bytes into bus_wdata, then -> WCOMMIT.
  - WCOMMIT: bus_we = 1 for one cycle. If words remain, bus_addr += 1 and -> WDATA; else -> WACK.
  - WACK: tx_we = ~tx_full with tx_data = WR_ACK; -> IDLE on push.
  - RREQ: bus_re = 1 for one cycle; -> RWAIT.
  - RWAIT:
    - Latch bus_rdata on bus_rvalid, then -> RSEND. bus_rvalid in the same cycle as bus_re is ignored; bus_rvalid outside RWAIT is ignored.
    - If bus_rvalid has not arrived after RD_TIMEOUT cycles, latch all-ones, set rd_err, and -> RSEND.
    - The timeout counter clears on entry to RWAIT.
  - RSEND:
    - Emit the latched word MSB byte first, one byte per cycle with tx_full == 0.
    - When tx_full is high: tx_we = 0 and the byte index holds.
    - After the last byte: if words remain, bus_addr += 1 and -> RREQ; else -> IDLE.
- Address increment wraps modulo 2^AW; a burst crossing the top continues from 0.
- Latency:
  - Write: bus_we asserts 1 cycle after the last data byte of each word is popped.
  - Read: bus_re asserts 1 cycle after LEN is popped. The first TX byte goes out 1 cycle after bus_rvalid, provided tx_full is 0.
- RX starvation mid-frame stalls indefinitely; there is no frame timeout.
- No bytes are popped during read states. Bytes that arrive during a read burst stay queued for the next frame.

Decomposition:
- Package qmfir_uart_pkg holds:
  - the state encoding (IDLE, ADDR, LEN, WDATA, WCOMMIT, WACK, RREQ, RWAIT, RSEND);
  - CMD bit positions (CMD_WR = 7, CMD_SEL = 6);
  - the default WR_ACK value.
- One sub-module is natural: qmfir_byte_shreg, a parametrised N-byte shift-in / shift-out register with byte counter and last-byte flag. It is instanced for the address, write data and read data.
- The top level keeps the FSM, the word counter and the timeout counter.

Test Plan:
- Single write: bytes 80 00 10 00 DE AD BE EF -> one bus_we with bus_sel = 0, bus_addr = 0x0010, bus_wdata = 0xDEADBEEF; TX emits A5.
- Burst write: CMD C0, addr 0x0100, LEN 02, then 12 data bytes -> three bus_we at 0x0100, 0x0101, 0x0102 with bus_sel = 1, then a single A5.
- Burst read under back-pressure:
  - Frame 40 FF FF 01; bus answers 0x11223344, then 0x55667788, each after 3 cycles.
  - tx_full toggles every other cycle.
  - Required: bus_re at 0xFFFF then 0x0000 (wrap); TX emits 11 22 33 44 55 66 77 88 with no drop or duplicate.
- Read timeout: frame 00 00 05 00 with bus_rvalid never asserted -> TX emits FF FF FF FF after RD_TIMEOUT cycles, rd_err = 1 and stays set across later frames until rst.
- Reset mid-burst: assert rst after the 2nd data byte of a write -> no bus_we, outputs return to reset values, next frame decodes correctly from its CMD byte.
- Parameter sweep: DATA_BYTES = 2, ADDR_BYTES = 1, frame 80 07 00 AB CD -> bus_addr = 0x07, bus_wdata = 0xABCD.
